temp_read_sequencer: RTL and testbench

//  Sequences periodic reads of the I2C temperature sensor through a byte-level I2C master.

---
 rtl/temp_read_sequencer.sv | 141 ++++++++++++++
 tb/tb_temp_read_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_read_sequencer.sv
// rtl/temp_read_sequencer.sv - periodic/triggered I2C temperature read sequencer
// Drives a byte-level I2C master through START, W addr, W ptr, rSTART, R addr, MSB, LSB, STOP.
module temp_read_sequencer #(
  parameter logic [31:0] PERIOD_CYC = 32'd100_000_000,
  parameter logic [6:0]  DEV_ADDR   = 7'h4B,
  parameter logic [7:0]  REG_PTR    = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        auto_en,
  input  logic        trig,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_op,
  output logic [7:0]  cmd_data,
  input  logic        rsp_valid,
  input  logic        rsp_nack,
  input  logic [7:0]  rsp_data,
  output logic        busy,
  output logic [15:0] raw,
  output logic [7:0]  temp,
  output logic        valid_pulse,
  output logic [7:0]  err_cnt
);

  localparam logic [2:0] OP_START     = 3'd0;
  localparam logic [2:0] OP_WRITE     = 3'd1;
  localparam logic [2:0] OP_READ_ACK  = 3'd2;
  localparam logic [2:0] OP_READ_NACK = 3'd3;
  localparam logic [2:0] OP_STOP      = 3'd4;

  typedef enum logic [3:0] {IDLE, S1, WA, WP, S2, RA, RM, RL, STP, DONE} state_t;

  state_t      state, state_nxt;
  logic        waiting;
  logic        err_flag;
  logic        pending;
  logic [31:0] period_cnt;
  logic [7:0]  msb_sh, lsb_sh;
  logic        wrap, rsp_hit, write_nack, is_cmd;

  assign wrap       = auto_en && (period_cnt == PERIOD_CYC - 32'd1);
  assign rsp_hit    = waiting && rsp_valid;
  assign write_nack = rsp_hit && rsp_nack && (state == WA || state == WP || state == RA);
  assign is_cmd     = (state != IDLE) && (state != DONE);
  // Each command state issues once, then parks with cmd_valid low until its response.
  assign cmd_valid   = is_cmd && !waiting;
  assign busy        = (state != IDLE);
  assign valid_pulse = (state == DONE);
  assign temp        = {raw[14:8], raw[7]};

  always_comb begin
    state_nxt = state;
    cmd_op    = OP_START;
    cmd_data  = 8'h00;
    case (state)
      IDLE: if (pending) state_nxt = S1;
      S1: begin
        cmd_op = OP_START;
        if (rsp_hit) state_nxt = WA;
      end
      WA: begin
        cmd_op   = OP_WRITE;
        cmd_data = {DEV_ADDR, 1'b0};
        if (write_nack) state_nxt = STP;
        else if (rsp_hit) state_nxt = WP;
      end
      WP: begin
        cmd_op   = OP_WRITE;
        cmd_data = REG_PTR;
        if (write_nack) state_nxt = STP;
        else if (rsp_hit) state_nxt = S2;
      end
      S2: begin
        cmd_op = OP_START;
        if (rsp_hit) state_nxt = RA;
      end
      RA: begin
        cmd_op   = OP_WRITE;
        cmd_data = {DEV_ADDR, 1'b1};
        if (write_nack) state_nxt = STP;
        else if (rsp_hit) state_nxt = RM;
      end
      RM: begin
        cmd_op = OP_READ_ACK;
        if (rsp_hit) state_nxt = RL;
      end
      RL: begin
        cmd_op = OP_READ_NACK;
        if (rsp_hit) state_nxt = STP;
      end
      STP: begin
        cmd_op = OP_STOP;
        if (rsp_hit) state_nxt = err_flag ? IDLE : DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      waiting    <= 1'b0;
      err_flag   <= 1'b0;
      pending    <= 1'b0;
      period_cnt <= 32'd0;
      msb_sh     <= 8'h00;
      lsb_sh     <= 8'h00;
      raw        <= 16'h0000;
      err_cnt    <= 8'h00;
    end else begin
      state <= state_nxt;

      if (!auto_en || wrap) period_cnt <= 32'd0;
      else                  period_cnt <= period_cnt + 32'd1;

      // A request coinciding with the IDLE->S1 launch is served by that launch.
      if (state == IDLE && pending)  pending <= 1'b0;
      else if (trig || wrap)         pending <= 1'b1;

      if (cmd_valid && cmd_ready) waiting <= 1'b1;
      else if (rsp_hit)           waiting <= 1'b0;

      if (state == IDLE)   err_flag <= 1'b0;
      else if (write_nack) err_flag <= 1'b1;

      if (rsp_hit && state == RM) msb_sh <= rsp_data;
      if (rsp_hit && state == RL) lsb_sh <= rsp_data;

      if (rsp_hit && state == STP) begin
        if (err_flag) begin
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
        end else begin
          raw <= {msb_sh, lsb_sh};
        end
      end
    end
  end

endmodule

// File: tb/tb_temp_read_sequencer.sv
// tb/tb_temp_read_sequencer.sv - self-checking bench for temp_read_sequencer
// Bench-side I2C master model plus transaction-level reference for ops, readings and error count.
module tb_temp_read_sequencer;

  localparam logic [6:0] DEV = 7'h4B;

  logic        clk = 1'b0;
  logic        reset, auto_en, trig;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid, rsp_nack;
  logic [7:0]  rsp_data;
  logic        busy, valid_pulse;
  logic [15:0] raw;
  logic [7:0]  temp, err_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vp_cnt = 0;

  int latency = 1;
  int lat_cnt = 0;
  int cmd_idx = 0;
  int nack_at = -1;
  int stall_idx = -1;
  int stall_left = 0;
  logic        pend_nack;
  logic [7:0]  pend_data;
  logic [7:0]  rd_q[$];
  logic [10:0] log_q[$];
  logic [10:0] exp_q[$];
  int          start_q[$];

  logic [15:0] exp_raw = 16'h0000;
  int          exp_err = 0;

  temp_read_sequencer #(.PERIOD_CYC(32'd200), .DEV_ADDR(DEV), .REG_PTR(8'h00)) dut (
    .clk(clk), .reset(reset), .auto_en(auto_en), .trig(trig),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_data(rsp_data),
    .busy(busy), .raw(raw), .temp(temp), .valid_pulse(valid_pulse), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    if (valid_pulse === 1'b1) vp_cnt++;
  end

  // I2C master model: handshake decided at negedge, response after 'latency' cycles.
  initial begin
    cmd_ready = 1'b1; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
      if (reset) begin
        lat_cnt = 0; cmd_idx = 0; cmd_ready = 1'b1;
      end else if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          rsp_valid = 1'b1; rsp_nack = pend_nack; rsp_data = pend_data;
        end
      end else if (cmd_valid === 1'b1) begin
        if (cmd_idx == stall_idx && stall_left > 0) begin
          cmd_ready = 1'b0;
          stall_left--;
        end else begin
          cmd_ready = 1'b1;
          log_q.push_back({cmd_op, cmd_data});
          if (cmd_op == 3'd0 && cmd_idx == 0) start_q.push_back(cyc);
          pend_nack = (cmd_op == 3'd1 && cmd_idx == nack_at);
          pend_data = 8'h00;
          if ((cmd_op == 3'd2 || cmd_op == 3'd3) && rd_q.size() > 0) pend_data = rd_q.pop_front();
          if (cmd_op == 3'd4) cmd_idx = 0;
          else cmd_idx = cmd_idx + 1;
          lat_cnt = latency;
        end
      end
    end
  end

  function automatic logic [7:0] model_temp(input logic [15:0] r);
    logic signed [15:0] s;
    s = r;
    s = s >>> 7;
    return s[7:0];
  endfunction

  // Expected command list; a NACKed write cuts the transaction straight to STOP.
  task automatic build_exp(input int nk);
    logic [10:0] full[8];
    full[0] = {3'd0, 8'h00};
    full[1] = {3'd1, DEV, 1'b0};
    full[2] = {3'd1, 8'h00};
    full[3] = {3'd0, 8'h00};
    full[4] = {3'd1, DEV, 1'b1};
    full[5] = {3'd2, 8'h00};
    full[6] = {3'd3, 8'h00};
    full[7] = {3'd4, 8'h00};
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(full[i]);
      if (i == nk) begin
        exp_q.push_back({3'd4, 8'h00});
        break;
      end
    end
  endtask

  task automatic pulse_trig();
    @(posedge clk); #1;
    trig = 1'b1;
    @(posedge clk); #1;
    trig = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int limit, output bit ok);
    int n;
    n = 0;
    while (busy !== lvl && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (busy === lvl);
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1; auto_en = 1'b0; trig = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({cmd_valid, busy, valid_pulse} !== 3'b000) begin
        failures++;
        if (bad < 5) $display("FAIL reset_idle: cycle %0d cmd_valid/busy/valid_pulse=%b expected 000", i, {cmd_valid, busy, valid_pulse});
        bad++;
      end
    end
    checks++;
    if (raw !== 16'h0000) begin failures++; $display("FAIL reset_raw: got %h expected 0000", raw); end
    checks++;
    if (temp !== 8'h00) begin failures++; $display("FAIL reset_temp: got %h expected 00", temp); end
    checks++;
    if (err_cnt !== 8'h00) begin failures++; $display("FAIL reset_err_cnt: got %h expected 00", err_cnt); end
  endtask

  task automatic test_read();
    logic [7:0] m[8], l[8];
    bit ok1, ok2;
    int vp0;
    m[0] = 8'h19; l[0] = 8'h80;
    m[1] = 8'hF3; l[1] = 8'h80;
    for (int i = 2; i < 8; i++) begin m[i] = 8'($urandom); l[i] = 8'($urandom); end
    for (int i = 0; i < 8; i++) begin
      latency = $urandom_range(1, 4); nack_at = -1;
      rd_q.delete(); rd_q.push_back(m[i]); rd_q.push_back(l[i]);
      log_q.delete(); build_exp(-1);
      exp_raw = {m[i], l[i]};
      vp0 = vp_cnt;
      pulse_trig();
      wait_busy(1'b1, 50, ok1);
      wait_busy(1'b0, 500, ok2);
      checks++;
      if (!(ok1 && ok2)) begin failures++; $display("FAIL read_timeout: case %0d busy=%b expected completed transaction", i, busy); end
      checks++;
      if (log_q.size() !== exp_q.size()) begin
        failures++; $display("FAIL read_op_count: case %0d got %0d expected %0d", i, log_q.size(), exp_q.size());
      end else begin
        for (int j = 0; j < exp_q.size(); j++) begin
          checks++;
          if (log_q[j] !== exp_q[j]) begin failures++; $display("FAIL read_op: case %0d idx %0d got %h expected %h", i, j, log_q[j], exp_q[j]); end
        end
      end
      checks++;
      if (raw !== exp_raw) begin failures++; $display("FAIL read_raw: case %0d got %h expected %h", i, raw, exp_raw); end
      checks++;
      if (temp !== model_temp(exp_raw)) begin failures++; $display("FAIL read_temp: case %0d got %h expected %h", i, temp, model_temp(exp_raw)); end
      checks++;
      if (vp_cnt - vp0 !== 1) begin failures++; $display("FAIL read_valid_pulse: case %0d got %0d expected 1", i, vp_cnt - vp0); end
      checks++;
      if (err_cnt !== 8'(exp_err)) begin failures++; $display("FAIL read_err_cnt: case %0d got %0d expected %0d", i, err_cnt, exp_err); end
    end
  endtask

  task automatic test_nack();
    int picks[3];
    bit ok1, ok2;
    int vp0;
    picks[0] = 1; picks[1] = 2; picks[2] = 4;
    for (int i = 0; i < 6; i++) begin
      latency = $urandom_range(1, 3);
      nack_at = (i == 0) ? 1 : picks[$urandom_range(0, 2)];
      rd_q.delete(); rd_q.push_back(8'($urandom)); rd_q.push_back(8'($urandom));
      log_q.delete(); build_exp(nack_at);
      if (exp_err < 255) exp_err++;
      vp0 = vp_cnt;
      pulse_trig();
      wait_busy(1'b1, 50, ok1);
      wait_busy(1'b0, 500, ok2);
      checks++;
      if (!(ok1 && ok2)) begin failures++; $display("FAIL nack_timeout: case %0d busy=%b expected completed transaction", i, busy); end
      checks++;
      if (log_q.size() !== exp_q.size()) begin
        failures++; $display("FAIL nack_op_count: case %0d nack_at %0d got %0d expected %0d", i, nack_at, log_q.size(), exp_q.size());
      end else begin
        for (int j = 0; j < exp_q.size(); j++) begin
          checks++;
          if (log_q[j] !== exp_q[j]) begin failures++; $display("FAIL nack_op: case %0d idx %0d got %h expected %h", i, j, log_q[j], exp_q[j]); end
        end
      end
      checks++;
      if (err_cnt !== 8'(exp_err)) begin failures++; $display("FAIL nack_err_cnt: case %0d got %0d expected %0d", i, err_cnt, exp_err); end
      checks++;
      if (raw !== exp_raw) begin failures++; $display("FAIL nack_raw: case %0d got %h expected %h", i, raw, exp_raw); end
      checks++;
      if (vp_cnt - vp0 !== 0) begin failures++; $display("FAIL nack_valid_pulse: case %0d got %0d expected 0", i, vp_cnt - vp0); end
    end
    nack_at = -1;
    rd_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok1;
    int vp0, s0, n, falls;
    logic prev;
    logic [7:0] b[4];
    latency = 2; nack_at = -1;
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    rd_q.delete();
    for (int i = 0; i < 4; i++) rd_q.push_back(b[i]);
    log_q.delete();
    vp0 = vp_cnt; s0 = start_q.size();
    pulse_trig();
    wait_busy(1'b1, 50, ok1);
    pulse_trig();
    pulse_trig();
    n = 0; falls = 0; prev = busy;
    while ((vp_cnt - vp0 < 2 || busy !== 1'b0) && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (prev === 1'b1 && busy === 1'b0) falls++;
      prev = busy;
    end
    repeat (60) @(posedge clk);
    #1;
    exp_raw = {b[2], b[3]};
    checks++;
    if (!ok1 || n >= 1000) begin failures++; $display("FAIL b2b_timeout: busy=%b pulses=%0d expected two transactions", busy, vp_cnt - vp0); end
    checks++;
    if (start_q.size() - s0 !== 2) begin failures++; $display("FAIL b2b_starts: got %0d expected 2", start_q.size() - s0); end
    checks++;
    if (vp_cnt - vp0 !== 2) begin failures++; $display("FAIL b2b_valid_pulse: got %0d expected 2", vp_cnt - vp0); end
    checks++;
    if (falls !== 2) begin failures++; $display("FAIL b2b_idle_gap: busy falls got %0d expected 2", falls); end
    checks++;
    if (log_q.size() !== 16) begin failures++; $display("FAIL b2b_op_count: got %0d expected 16", log_q.size()); end
    checks++;
    if (raw !== exp_raw) begin failures++; $display("FAIL b2b_raw: got %h expected %h", raw, exp_raw); end
  endtask

  task automatic test_period();
    int vp0;
    latency = 3; nack_at = -1;
    rd_q.delete(); start_q.delete(); log_q.delete();
    vp0 = vp_cnt;
    @(posedge clk); #1;
    auto_en = 1'b1;
    repeat (1100) @(posedge clk);
    #1 auto_en = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    exp_raw = 16'h0000;
    checks++;
    if (start_q.size() !== 5) begin failures++; $display("FAIL period_starts: got %0d expected 5", start_q.size()); end
    for (int i = 1; i < start_q.size(); i++) begin
      checks++;
      if (start_q[i] - start_q[i-1] !== 200) begin failures++; $display("FAIL period_interval: idx %0d got %0d expected 200", i, start_q[i] - start_q[i-1]); end
    end
    checks++;
    if (vp_cnt - vp0 !== 5) begin failures++; $display("FAIL period_valid_pulse: got %0d expected 5", vp_cnt - vp0); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL period_idle_after_disable: busy got %b expected 0", busy); end
  endtask

  task automatic test_stall_reset();
    int n;
    latency = 1; nack_at = -1;
    stall_idx = 2; stall_left = 10;
    rd_q.delete(); rd_q.push_back(8'h55); rd_q.push_back(8'hAA);
    log_q.delete();
    pulse_trig();
    n = 0;
    while (!(cmd_valid === 1'b1 && cmd_op === 3'd1 && cmd_data === 8'h00) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 200) begin failures++; $display("FAIL stall_reach_wp: cmd_op %0d cmd_data %h expected WP write", cmd_op, cmd_data); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({cmd_valid, cmd_op, cmd_data} !== {1'b1, 3'd1, 8'h00}) begin
        failures++; $display("FAIL stall_stable: cycle %0d got %b/%0d/%h expected 1/1/00", i, cmd_valid, cmd_op, cmd_data);
      end
      @(posedge clk); #1;
    end
    stall_idx = -1;
    n = 0;
    while (!(cmd_valid === 1'b1 && cmd_op === 3'd2) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 200) begin failures++; $display("FAIL reset_reach_rm: cmd_op %0d expected READ_ACK", cmd_op); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_valid !== 1'b0) begin failures++; $display("FAIL midreset_cmd_valid: got %b expected 0", cmd_valid); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    exp_raw = 16'h0000; exp_err = 0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (log_q.size() !== 5 || log_q[log_q.size()-1] !== {3'd1, DEV, 1'b1}) begin
      failures++; $display("FAIL midreset_no_stop: ops %0d last %h expected 5 ending %h", log_q.size(), log_q[log_q.size()-1], {3'd1, DEV, 1'b1});
    end
    checks++;
    if (raw !== exp_raw || err_cnt !== 8'(exp_err)) begin failures++; $display("FAIL midreset_outputs: raw %h err_cnt %0d expected 0000/0", raw, err_cnt); end
    rd_q.delete();
  endtask

  task automatic test_err_saturate();
    bit ok1, ok2;
    int to;
    latency = 1; nack_at = 1; to = 0;
    for (int i = 0; i < 258; i++) begin
      pulse_trig();
      wait_busy(1'b1, 50, ok1);
      wait_busy(1'b0, 200, ok2);
      if (!(ok1 && ok2)) to++;
      if (exp_err < 255) exp_err++;
      if (i == 253) begin
        checks++;
        if (err_cnt !== 8'(exp_err)) begin failures++; $display("FAIL err_cnt_pre_sat: got %0d expected %0d", err_cnt, exp_err); end
      end
    end
    checks++;
    if (to !== 0) begin failures++; $display("FAIL sat_timeout: got %0d timeouts expected 0", to); end
    checks++;
    if (err_cnt !== 8'(exp_err)) begin failures++; $display("FAIL err_cnt_saturate: got %0d expected %0d", err_cnt, exp_err); end
    checks++;
    if (raw !== exp_raw) begin failures++; $display("FAIL sat_raw: got %h expected %h", raw, exp_raw); end
    nack_at = -1;
  endtask

  initial begin
    reset = 1'b1; auto_en = 1'b0; trig = 1'b0;
    test_reset();
    test_read();
    test_nack();
    test_back_to_back();
    test_period();
    test_stall_reset();
    test_err_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
